player_input_conditioner: RTL and testbench

//  Input-side counterpart to the display/score output path: turns raw DE0 BUTTON/SW pins into clean, synchronous player events.

---
 rtl/flippy_pkg.sv | 13 +
 rtl/debounce_bit.sv | 48 ++++
 rtl/player_input_conditioner.sv | 72 +++++++
 tb/tb_player_input_conditioner.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/flippy_pkg.sv
// Shared constants for the Flippy player input path.
// Debounce depth, button count, switch width, button indices.
package flippy_pkg;

  localparam int DEBOUNCE_CYCLES = 500000;
  localparam int NUM_BUTTONS     = 3;
  localparam int SW_WIDTH        = 8;

  localparam int BTN_DROP  = 0;
  localparam int BTN_MOVE  = 1;
  localparam int BTN_RESET = 2;

endpackage

// File: rtl/debounce_bit.sv
// One push button: 2-FF sync, invert, debounce, press/release strobes.
// Ports: clock, reset_n, raw_n (active-low pin), level, press, unpress.
module debounce_bit
  import flippy_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = flippy_pkg::DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw_n,
  output logic level,
  output logic press,
  output logic unpress
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt;
  logic          pressed;

  assign pressed = ~sync_q[1];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= 2'b11;
      cnt     <= '0;
      level   <= 1'b0;
      press   <= 1'b0;
      unpress <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], raw_n};
      press   <= 1'b0;
      unpress <= 1'b0;
      if (pressed == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level   <= pressed;
        cnt     <= '0;
        press   <= pressed;
        unpress <= ~pressed;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/player_input_conditioner.sv
// Raw DE0 buttons/switches -> clean synchronous player events.
// Ports: clock, reset_n, button_raw, sw_raw -> button_level/press/release, sw_stable, sw_changed.
module player_input_conditioner
  import flippy_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = flippy_pkg::DEBOUNCE_CYCLES,
  parameter int NUM_BUTTONS     = flippy_pkg::NUM_BUTTONS,
  parameter int SW_WIDTH        = flippy_pkg::SW_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NUM_BUTTONS-1:0] button_raw,
  input  logic [SW_WIDTH-1:0]    sw_raw,
  output logic [NUM_BUTTONS-1:0] button_level,
  output logic [NUM_BUTTONS-1:0] button_press,
  output logic [NUM_BUTTONS-1:0] button_release,
  output logic [SW_WIDTH-1:0]    sw_stable,
  output logic                   sw_changed
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clock  (clock),
      .reset_n(reset_n),
      .raw_n  (button_raw[i]),
      .level  (button_level[i]),
      .press  (button_press[i]),
      .unpress(button_release[i])
    );
  end

  logic [SW_WIDTH-1:0] sw_s1;
  logic [SW_WIDTH-1:0] sw_sync;
  logic [SW_WIDTH-1:0] cand;
  logic [CW-1:0]       sw_cnt;

  // Loading a new candidate counts as its first stable cycle, so the
  // word path has the same latency as a button. Candidate follows
  // sw_stable while idle so any departure always reloads.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sw_s1      <= '0;
      sw_sync    <= '0;
      cand       <= '0;
      sw_cnt     <= '0;
      sw_stable  <= '0;
      sw_changed <= 1'b0;
    end else begin
      sw_s1      <= sw_raw;
      sw_sync    <= sw_s1;
      sw_changed <= 1'b0;
      if (sw_sync == sw_stable) begin
        cand   <= sw_stable;
        sw_cnt <= '0;
      end else if (sw_sync != cand) begin
        cand   <= sw_sync;
        sw_cnt <= CW'(1);
      end else if (sw_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        sw_stable  <= cand;
        sw_cnt     <= '0;
        sw_changed <= 1'b1;
      end else begin
        sw_cnt <= sw_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_player_input_conditioner.sv
// Directed bench for player_input_conditioner, DEBOUNCE_CYCLES = 8.
// Table of {inputs, wait, expected outputs} plus reset sequences.
module tb_player_input_conditioner;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [2:0] button_raw;
  logic [7:0] sw_raw;
  logic [2:0] button_level;
  logic [2:0] button_press;
  logic [2:0] button_release;
  logic [7:0] sw_stable;
  logic       sw_changed;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  player_input_conditioner #(
    .DEBOUNCE_CYCLES(8),
    .NUM_BUTTONS    (3),
    .SW_WIDTH       (8)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .button_raw    (button_raw),
    .sw_raw        (sw_raw),
    .button_level  (button_level),
    .button_press  (button_press),
    .button_release(button_release),
    .sw_stable     (sw_stable),
    .sw_changed    (sw_changed)
  );

  typedef struct {
    logic [2:0] btn;
    logic [7:0] sw;
    int         n;
    logic [2:0] lvl;
    logic [2:0] prs;
    logic [2:0] rel;
    logic [7:0] sws;
    logic       chg;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, exp);
    end
  endtask

  task automatic chk_all(input string tag,
                         input logic [2:0] lvl,
                         input logic [2:0] prs,
                         input logic [2:0] rel,
                         input logic [7:0] sws,
                         input logic       chg);
    chk({tag, "_level"},   {5'd0, button_level},   {5'd0, lvl});
    chk({tag, "_press"},   {5'd0, button_press},   {5'd0, prs});
    chk({tag, "_release"}, {5'd0, button_release}, {5'd0, rel});
    chk({tag, "_sw"},      sw_stable,              sws);
    chk({tag, "_chg"},     {7'd0, sw_changed},     {7'd0, chg});
  endtask

  initial begin
    // button 0 press/release latency
    tbl.push_back('{3'b110, 8'h00, 9, 3'b000, 3'b000, 3'b000, 8'h00, 1'b0});
    tbl.push_back('{3'b110, 8'h00, 1, 3'b001, 3'b001, 3'b000, 8'h00, 1'b0});
    tbl.push_back('{3'b110, 8'h00, 1, 3'b001, 3'b000, 3'b000, 8'h00, 1'b0});
    tbl.push_back('{3'b110, 8'h00, 8, 3'b001, 3'b000, 3'b000, 8'h00, 1'b0});
    tbl.push_back('{3'b111, 8'h00, 9, 3'b001, 3'b000, 3'b000, 8'h00, 1'b0});
    tbl.push_back('{3'b111, 8'h00, 1, 3'b000, 3'b000, 3'b001, 8'h00, 1'b0});
    tbl.push_back('{3'b111, 8'h00, 1, 3'b000, 3'b000, 3'b000, 8'h00, 1'b0});
    // button 1 bouncing every 3 cycles, then held
    for (int i = 0; i < 10; i++)
      tbl.push_back('{(i % 2 == 0) ? 3'b101 : 3'b111, 8'h00, 3,
                      3'b000, 3'b000, 3'b000, 8'h00, 1'b0});
    tbl.push_back('{3'b101, 8'h00, 9, 3'b000, 3'b000, 3'b000, 8'h00, 1'b0});
    tbl.push_back('{3'b101, 8'h00, 1, 3'b010, 3'b010, 3'b000, 8'h00, 1'b0});
    tbl.push_back('{3'b101, 8'h00, 1, 3'b010, 3'b000, 3'b000, 8'h00, 1'b0});
    // switch word
    tbl.push_back('{3'b101, 8'hA5, 9, 3'b010, 3'b000, 3'b000, 8'h00, 1'b0});
    tbl.push_back('{3'b101, 8'hA5, 1, 3'b010, 3'b000, 3'b000, 8'hA5, 1'b1});
    tbl.push_back('{3'b101, 8'hA5, 1, 3'b010, 3'b000, 3'b000, 8'hA5, 1'b0});
    tbl.push_back('{3'b101, 8'h3C, 5, 3'b010, 3'b000, 3'b000, 8'hA5, 1'b0});
    tbl.push_back('{3'b101, 8'h3D, 9, 3'b010, 3'b000, 3'b000, 8'hA5, 1'b0});
    tbl.push_back('{3'b101, 8'h3D, 1, 3'b010, 3'b000, 3'b000, 8'h3D, 1'b1});
    tbl.push_back('{3'b101, 8'h3D, 1, 3'b010, 3'b000, 3'b000, 8'h3D, 1'b0});
    // release button 1
    tbl.push_back('{3'b111, 8'h3D, 9, 3'b010, 3'b000, 3'b000, 8'h3D, 1'b0});
    tbl.push_back('{3'b111, 8'h3D, 1, 3'b000, 3'b000, 3'b010, 8'h3D, 1'b0});
    // simultaneous buttons 0,2 and switch change
    tbl.push_back('{3'b010, 8'h77, 9, 3'b000, 3'b000, 3'b000, 8'h3D, 1'b0});
    tbl.push_back('{3'b010, 8'h77, 1, 3'b101, 3'b101, 3'b000, 8'h77, 1'b1});
    tbl.push_back('{3'b010, 8'h77, 1, 3'b101, 3'b000, 3'b000, 8'h77, 1'b0});
    tbl.push_back('{3'b111, 8'h77, 9, 3'b101, 3'b000, 3'b000, 8'h77, 1'b0});
    tbl.push_back('{3'b111, 8'h77, 1, 3'b000, 3'b000, 3'b101, 8'h77, 1'b0});
    tbl.push_back('{3'b111, 8'h77, 1, 3'b000, 3'b000, 3'b000, 8'h77, 1'b0});

    // reset held, then idle
    reset_n    = 1'b0;
    button_raw = 3'b111;
    sw_raw     = 8'h00;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk_all($sformatf("rst%0d", i), 3'b000, 3'b000, 3'b000, 8'h00, 1'b0);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      chk_all($sformatf("idle%0d", i), 3'b000, 3'b000, 3'b000, 8'h00, 1'b0);
    end

    foreach (tbl[i]) begin
      button_raw = tbl[i].btn;
      sw_raw     = tbl[i].sw;
      repeat (tbl[i].n) @(posedge clock);
      @(negedge clock);
      chk_all($sformatf("v%0d", i), tbl[i].lvl, tbl[i].prs,
              tbl[i].rel, tbl[i].sws, tbl[i].chg);
    end

    // reset in the middle of a press count, inputs held through reset
    button_raw = 3'b110;
    repeat (7) @(posedge clock);
    #1 reset_n = 1'b0;
    #1 chk_all("midrst", 3'b000, 3'b000, 3'b000, 8'h00, 1'b0);
    repeat (3) @(negedge clock);
    chk_all("midrst_hold", 3'b000, 3'b000, 3'b000, 8'h00, 1'b0);
    reset_n = 1'b1;
    repeat (9) @(posedge clock);
    @(negedge clock);
    chk_all("post9", 3'b000, 3'b000, 3'b000, 8'h00, 1'b0);
    @(posedge clock);
    @(negedge clock);
    chk_all("post10", 3'b001, 3'b001, 3'b000, 8'h77, 1'b1);
    @(posedge clock);
    @(negedge clock);
    chk_all("post11", 3'b001, 3'b000, 3'b000, 8'h77, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
